// File: rtl/priority_seq_if.sv
`default_nettype none
// ============================================================================
// priority_seq_if : control/grant bundle between a requester and priority_seq
// Rev 1.0
// ============================================================================
interface priority_seq_if #(
  parameter int N_CH = 16,
  parameter int IW   = $clog2(N_CH)
);
  localparam int PW = $clog2(N_CH) + 1;

  logic [N_CH-1:0] ch_req_i;
  logic            arm_i;
  logic            dump_i;
  logic            disable_i;
  logic [N_CH-1:0] ch_sel_o;
  logic [IW-1:0]   ch_idx_o;
  logic            valid_o;
  logic            last_o;
  logic            busy_o;
  logic            done_o;
  logic [PW-1:0]   pending_o;

  modport master (
    output ch_req_i, arm_i, dump_i, disable_i,
    input  ch_sel_o, ch_idx_o, valid_o, last_o, busy_o, done_o, pending_o
  );

  modport slave (
    input  ch_req_i, arm_i, dump_i, disable_i,
    output ch_sel_o, ch_idx_o, valid_o, last_o, busy_o, done_o, pending_o
  );
endinterface
`default_nettype wire

// File: rtl/priority_seq.sv
`default_nettype none
// ============================================================================
// priority_seq : arms a channel request mask and grants pending channels one
//                per dump, fixed-priority or round-robin
// Rev 1.0
// ============================================================================
module priority_seq #(
  parameter int N_CH    = 16,
  parameter int RR_MODE = 0,
  parameter int IW      = $clog2(N_CH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  priority_seq_if.slave bus
);
  localparam int            SW      = $clog2(N_CH);
  localparam int            PW      = SW + 1;
  localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [N_CH-1:0] mask, mask_d;
  logic [SW-1:0]   idx, idx_d;
  logic [SW-1:0]   ptr, ptr_d;
  logic            done, done_d;

  int              base;
  int              cand;
  logic            pick_found;
  logic [SW-1:0]   pick_idx;
  logic [N_CH-1:0] grant_bit;
  logic [PW-1:0]   pop;

  // Scan downward over the search offsets so the smallest offset wins.
  always_comb begin
    base = 0;
    if (RR_MODE != 0) begin
      base = int'(ptr) + 1;
      if (base >= N_CH) base = 0;
    end
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = base + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (mask[SW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = SW'(cand);
      end
    end
  end

  assign grant_bit = N_CH'(1) << pick_idx;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + PW'(mask[i]);
  end

  always_comb begin
    state_d = state;
    mask_d  = mask;
    idx_d   = idx;
    ptr_d   = ptr;
    done_d  = 1'b0;
    if (bus.disable_i) begin
      state_d = IDLE;
      mask_d  = '0;
      idx_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.arm_i) begin
            state_d = ARMED;
            mask_d  = bus.ch_req_i;
          end
        end
        ARMED, ACTIVE: begin
          if (bus.dump_i && !pick_found) begin
            state_d = IDLE;
            mask_d  = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else if (bus.dump_i) begin
            // Pick comes from the pre-merge mask; a re-request re-sets its bit.
            state_d = ACTIVE;
            idx_d   = pick_idx;
            ptr_d   = pick_idx;
            mask_d  = (mask & ~grant_bit) | (bus.arm_i ? bus.ch_req_i : '0);
          end else if (bus.arm_i) begin
            mask_d = mask | bus.ch_req_i;
          end
        end
        default: begin
          state_d = IDLE;
          mask_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      mask  <= '0;
      idx   <= '0;
      ptr   <= LAST_CH;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      mask  <= mask_d;
      idx   <= idx_d;
      ptr   <= ptr_d;
      done  <= done_d;
    end
  end

  assign bus.valid_o   = (state == ACTIVE);
  assign bus.ch_sel_o  = (state == ACTIVE) ? (N_CH'(1) << idx) : '0;
  assign bus.ch_idx_o  = (state == ACTIVE) ? IW'(idx) : '0;
  assign bus.last_o    = (mask == '0);
  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = done;
  assign bus.pending_o = pop;
endmodule
`default_nettype wire

// File: tb/tb_priority_seq.sv
`default_nettype none
// ============================================================================
// tb_priority_seq : fixed-priority and round-robin instances driven in lockstep
// Rev 1.0
// ============================================================================
module tb_priority_seq;
  localparam int N = 16;
  localparam int S_IDLE = 0, S_ARMED = 1, S_ACTIVE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          arm = 1'b0, dump = 1'b0, dis = 1'b0;

  int checks = 0;
  int failures = 0;
  string phase = "init";

  priority_seq_if #(.N_CH(N)) if0 ();
  priority_seq_if #(.N_CH(N)) if1 ();

  assign if0.ch_req_i = req;  assign if1.ch_req_i = req;
  assign if0.arm_i = arm;     assign if1.arm_i = arm;
  assign if0.dump_i = dump;   assign if1.dump_i = dump;
  assign if0.disable_i = dis; assign if1.disable_i = dis;

  priority_seq #(.N_CH(N), .RR_MODE(0)) u_fixed (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  priority_seq #(.N_CH(N), .RR_MODE(1)) u_rr    (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  // Reference: pending set as a bit array, current grant as an index (-1 none).
  int m_state[2];
  bit m_pend[2][N];
  int m_cur[2];
  int m_ptr[2];
  bit m_done[2];

  task automatic model_step(input int m);
    int cnt, ch, start;
    bit ended;
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m_pend[m][i]);
    m_done[m] = 1'b0;
    ended = 1'b0;
    if (rst) begin
      m_state[m] = S_IDLE;
      for (int i = 0; i < N; i++) m_pend[m][i] = 1'b0;
      m_cur[m] = -1;
      m_ptr[m] = N - 1;
    end else if (dis) begin
      m_state[m] = S_IDLE;
      for (int i = 0; i < N; i++) m_pend[m][i] = 1'b0;
      m_cur[m] = -1;
    end else if (m_state[m] == S_IDLE) begin
      if (arm) begin
        for (int i = 0; i < N; i++) m_pend[m][i] = req[i];
        m_state[m] = S_ARMED;
      end
    end else begin
      if (dump) begin
        if (cnt == 0) begin
          ended = 1'b1;
          m_state[m] = S_IDLE;
          m_cur[m] = -1;
          m_done[m] = 1'b1;
        end else begin
          start = (m == 1) ? (m_ptr[m] + 1) % N : 0;
          ch = -1;
          for (int off = 0; off < N && ch < 0; off++)
            if (m_pend[m][(start + off) % N]) ch = (start + off) % N;
          m_pend[m][ch] = 1'b0;
          m_cur[m] = ch;
          m_ptr[m] = ch;
          m_state[m] = S_ACTIVE;
        end
      end
      if (arm && !ended)
        for (int i = 0; i < N; i++) if (req[i]) m_pend[m][i] = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic compare(input int m, input logic [N-1:0] sel, input logic [3:0] idx,
                         input logic valid, input logic last, input logic busy,
                         input logic done, input logic [4:0] pend);
    int cnt;
    string p;
    p = (m == 1) ? "rr" : "fixed";
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m_pend[m][i]);
    check({p, ".sel"},   32'(sel),   (m_cur[m] >= 0) ? (32'd1 << m_cur[m]) : 32'd0);
    check({p, ".idx"},   32'(idx),   (m_cur[m] >= 0) ? 32'(m_cur[m]) : 32'd0);
    check({p, ".valid"}, 32'(valid), 32'(m_cur[m] >= 0));
    check({p, ".last"},  32'(last),  32'(cnt == 0));
    check({p, ".busy"},  32'(busy),  32'(m_state[m] != S_IDLE));
    check({p, ".done"},  32'(done),  32'(m_done[m]));
    check({p, ".pend"},  32'(pend),  32'(cnt));
  endtask

  task automatic step(input logic r, input logic d, input logic a, input logic du,
                      input logic [N-1:0] q);
    rst = r; dis = d; arm = a; dump = du; req = q;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0, if0.ch_sel_o, if0.ch_idx_o, if0.valid_o, if0.last_o, if0.busy_o,
            if0.done_o, if0.pending_o);
    compare(1, if1.ch_sel_o, if1.ch_idx_o, if1.valid_o, if1.last_o, if1.busy_o,
            if1.done_o, if1.pending_o);
  endtask

  task automatic dmp();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    int g32[4] = '{0, 5, 10, 15};
    int g33[3] = '{0, 1, 4};
    logic [N-1:0] rq;

    phase = "reset";
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    check("last_rst", 32'(if0.last_o), 32'd1);
    check("pend_rst", 32'(if1.pending_o), 32'd0);

    phase = "seq8421";
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h8421);
    for (int k = 0; k < 4; k++) begin
      dmp();
      check("grant", 32'(if0.ch_idx_o), 32'(g32[k]));
      check("last", 32'(if0.last_o), 32'(k == 3));
    end
    dmp();
    check("end_done", 32'(if0.done_o), 32'd1);
    check("end_valid", 32'(if0.valid_o), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("done_once", 32'(if0.done_o), 32'd0);

    phase = "rr_ptr";
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0011);
    dmp(); check("first0", 32'(if1.ch_idx_o), 32'd0);
    dmp(); check("first4", 32'(if1.ch_idx_o), 32'd4);
    dmp();
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0013);
    for (int k = 0; k < 3; k++) begin
      dmp();
      check("second", 32'(if1.ch_idx_o), 32'(g33[k]));
    end
    dmp();

    phase = "rr_wrap";
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h8001);
    dmp(); check("g0", 32'(if1.ch_idx_o), 32'd0);
    dmp(); check("g15", 32'(if1.ch_idx_o), 32'd15);
    dmp();
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h8001);
    dmp(); check("wrap0", 32'(if1.ch_idx_o), 32'd0);
    dmp(); dmp();

    phase = "rearm";
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0058);
    dmp(); check("on3", 32'(if0.ch_idx_o), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0008);
    check("old_mask", 32'(if0.ch_idx_o), 32'd4);
    dmp(); check("regrant3", 32'(if0.ch_idx_o), 32'd3);
    for (int k = 0; k < 4; k++) dmp();

    phase = "disable";
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h000F);
    dmp(); check("pend3", 32'(if0.pending_o), 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h00F0);
    check("busy", 32'(if0.busy_o), 32'd0);
    check("pend0", 32'(if0.pending_o), 32'd0);
    check("nodone", 32'(if0.done_o), 32'd0);

    phase = "midrst";
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0006);
    dmp();
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h00FF);
    check("sel", 32'(if0.ch_sel_o), 32'd0);
    check("done", 32'(if0.done_o), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    dmp();
    check("empty_done", 32'(if0.done_o), 32'd1);
    check("empty_valid", 32'(if1.valid_o), 32'd0);

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      rq = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rq = rq & 16'($urandom);
      step(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1) == 0), rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
